pwm_bank: RTL
=============

Name: pwm_bank

Overview:
Parametrised multi-channel PWM generator with an Avalon-MM slave register interface; the next generation of the fixed 8-bit pwm_0 conduit in soc_system.
- Adds configurable channel count and counter width.
- Adds a shared prescaler and edge- or center-aligned modes.
- Duty and period registers are double-buffered and take effect at the period boundary, so no glitches occur.
- Sits on the HPS lightweight bridge; pwm_out drives motor/servo/LED pins through the system conduit.

Parameters:
NUM_CHANNELS, 8, number of PWM outputs (1..28)
CNT_WIDTH, 16, width of period/duty/counter (2..32)
PRESC_WIDTH, 16, width of prescaler register/counter
ADDR_WIDTH, 5, Avalon word-address width; must satisfy 2^ADDR_WIDTH >= 4+NUM_CHANNELS

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous active-low reset
address  input  ADDR_WIDTH  Avalon word address
write  input  1  write strobe
writedata  input  32  write data
read  input  1  read strobe
readdata  output  32  read data, valid 1 cycle after read
pwm_out  output  NUM_CHANNELS  registered PWM outputs

Behaviour:
Register map (word addresses):
- 0 CTRL: bit0 EN, bit1 CENTER (0 = edge-aligned), rest reads 0.
- 1 PERIOD: CNT_WIDTH bits.
- 2 PRESCALE: PRESC_WIDTH bits.
- 3 CYCLES: 32-bit period counter; a write of any value clears it.
- 4+i DUTY[i]: CNT_WIDTH bits, for i < NUM_CHANNELS.
- Writes truncate to field width. Unmapped writes are ignored; unmapped reads return 0.
- No waitrequest. Fixed read latency of 1 cycle.

Reset (reset_n low at clk edge):
- All registers, shadows, prescaler, counter, direction flag and readdata go to 0.
- pwm_out = 0.
- Reset asserted mid-period aborts the period immediately.

Prescaler:
- presc_cnt counts 0..PRESCALE. tick asserts when presc_cnt == PRESCALE, then presc_cnt returns to 0.
- PRESCALE = 0 gives a tick every clk.
- Compare against the live PRESCALE register.

Counter, edge mode:
- On each tick, cnt increments 0..PERIOD_act and wraps to 0.
- Period = PERIOD_act+1 ticks.
- Boundary = tick with cnt == PERIOD_act.

Counter, center mode:
- cnt counts up 0..PERIOD_act, then down to 0; dir flips at each end.
- Period = 2*PERIOD_act ticks.
- Boundary = tick with dir = down and cnt == 1, or PERIOD_act == 0.

Boundary actions:
- PERIOD_act, DUTY_act[i] and CENTER_act load from their registers.
- CYCLES increments and wraps at 2^32.
- A same-cycle register write is not captured; it takes effect at the next boundary.
- A same-cycle write to CYCLES wins over the increment.

Compare:
- pwm_out[i] <= EN & (cnt < DUTY_act[i]), registered (1 clk latency from cnt).
- DUTY = 0 gives constant low.
- DUTY > PERIOD_act gives constant high in edge mode.
- DUTY >= PERIOD_act gives constant high in center mode.

EN = 0:
- Prescaler, cnt and dir are held at 0; pwm_out = 0 on the next clk.
- Active copies continuously track their registers.
- On EN 0->1, the first period starts at cnt = 0 with the current values.

Optional Feature:
Macro PWM_BANK_INVERT_EN.
- Defined: adds register at word address 2^ADDR_WIDTH-1, INVERT with NUM_CHANNELS bits (reset 0). pwm_out[i] = compare XOR INVERT_act[i]. INVERT_act loads at the boundary like DUTY. With EN = 0, outputs equal INVERT_act (idle level), still registered.
- Undefined: that address is unmapped (reads 0) and there is no inversion logic.

Test Plan:
1. Reset, then read all registers -> all 0, pwm_out = 0; CTRL=1, PERIOD=9, PRESCALE=0, DUTY[0]=3 -> pwm_out[0] high 3 clk, low 7 clk, repeating period 10; CYCLES increments every 10 clk.
2. PRESCALE=4, PERIOD=3, DUTY[1]=2, edge mode -> pwm_out[1] high 10 clk, low 10 clk; DUTY[1]=0 -> constant low; DUTY[1]=4 -> constant high, each starting at the next boundary.
3. Center mode, PERIOD=4, DUTY[2]=2, PRESCALE=0 -> period 8 clk, pwm_out[2] high 4 clk centered on cnt=0; write PERIOD=6 mid-period -> current period stays 8, next is 12.
4. Write DUTY[3] in the same cycle as a boundary -> the old duty runs one more full period, and the new duty applies after the following boundary.
5. Clear EN mid-period -> pwm_out = 0 next clk; re-set EN -> first high pulse starts at cnt=0; assert reset_n=0 mid-period -> all outputs and CYCLES are 0 next clk.
6. With PWM_BANK_INVERT_EN: INVERT=0x01, EN=0 -> pwm_out[0]=1; EN=1, DUTY[0]=3, PERIOD=9 -> low 3 clk, high 7 clk; without the macro, address 31 reads 0.

Source files
------------

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator behind an Avalon-MM slave, with a shared prescaler,
// edge/center alignment and double-buffered period/duty/mode that switch only at the period boundary.
// Optional INVERT register (idle level and output polarity) is built when PWM_BANK_INVERT_EN is defined.
module pwm_bank #(
  parameter int NUM_CHANNELS = 8,
  parameter int CNT_WIDTH    = 16,
  parameter int PRESC_WIDTH  = 16,
  parameter int ADDR_WIDTH   = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    write,
  input  logic [31:0]             writedata,
  input  logic                    read,
  output logic [31:0]             readdata,
  output logic [NUM_CHANNELS-1:0] pwm_out
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_PERIOD = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_PRESC  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CYCLES = ADDR_WIDTH'(3);
`ifdef PWM_BANK_INVERT_EN
  // Top word of the map. With a completely full map this aliases the last
  // DUTY slot; a write then lands in both and a read returns INVERT.
  localparam logic [ADDR_WIDTH-1:0] ADDR_INVERT = '1;
`endif

  // Software-visible registers
  logic                   en_q, en_d;
  logic                   center_q, center_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [31:0]            cycles_q, cycles_d;
  logic [CNT_WIDTH-1:0]   duty_q [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]   duty_d [NUM_CHANNELS];

  // Active copies used by the timebase and comparators
  logic                   center_act_q, center_act_d;
  logic [CNT_WIDTH-1:0]   period_act_q, period_act_d;
  logic [CNT_WIDTH-1:0]   duty_act_q [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]   duty_act_d [NUM_CHANNELS];

`ifdef PWM_BANK_INVERT_EN
  logic [NUM_CHANNELS-1:0] invert_q, invert_d;
  logic [NUM_CHANNELS-1:0] invert_act_q, invert_act_d;
`endif

  // Timebase and outputs
  logic [PRESC_WIDTH-1:0]  presc_cnt_q, presc_cnt_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    dir_q, dir_d;   // 1 = counting down (center mode)
  logic                    tick;
  logic                    boundary;
  logic [NUM_CHANNELS-1:0] pwm_q, pwm_d;
  logic [31:0]             readdata_q, readdata_d;
  logic [31:0]             rdata;

  assign readdata = readdata_q;
  assign pwm_out  = pwm_q;

  // Register writes: fields truncate to their width, unmapped addresses are ignored
  always_comb begin
    en_d     = en_q;
    center_d = center_q;
    period_d = period_q;
    presc_d  = presc_q;
    for (int i = 0; i < NUM_CHANNELS; i++) duty_d[i] = duty_q[i];
`ifdef PWM_BANK_INVERT_EN
    invert_d = invert_q;
`endif
    if (write) begin
      if (address == ADDR_CTRL) begin
        en_d     = writedata[0];
        center_d = writedata[1];
      end
      if (address == ADDR_PERIOD) period_d = writedata[CNT_WIDTH-1:0];
      if (address == ADDR_PRESC)  presc_d  = writedata[PRESC_WIDTH-1:0];
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (address == ADDR_WIDTH'(4 + i)) duty_d[i] = writedata[CNT_WIDTH-1:0];
      end
`ifdef PWM_BANK_INVERT_EN
      if (address == ADDR_INVERT) invert_d = writedata[NUM_CHANNELS-1:0];
`endif
    end
  end

  // Prescaler and period counter; everything parks at zero while disabled
  always_comb begin
    presc_cnt_d = '0;
    cnt_d       = '0;
    dir_d       = 1'b0;
    tick        = 1'b0;
    boundary    = 1'b0;
    if (en_q) begin
      tick        = (presc_cnt_q == presc_q);
      presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
      cnt_d       = cnt_q;
      dir_d       = dir_q;
      if (tick) begin
        if (!center_act_q) begin
          if (cnt_q == period_act_q) begin
            boundary = 1'b1;
            cnt_d    = '0;
            dir_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (period_act_q == '0) begin
          boundary = 1'b1;
          cnt_d    = '0;
          dir_d    = 1'b0;
        end else if (dir_q) begin
          if (cnt_q == CNT_WIDTH'(1)) begin
            boundary = 1'b1;
            cnt_d    = '0;
            dir_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end else begin
          // Direction turns on arrival at the top, so the peak belongs to the
          // down phase and a period is 0..P up, P-1..1 down = 2*P ticks.
          cnt_d = cnt_q + 1'b1;
          dir_d = (cnt_d == period_act_q);
        end
      end
    end
  end

  // Shadow-to-active transfer at the boundary (or continuously while disabled) and CYCLES
  always_comb begin
    center_act_d = center_act_q;
    period_act_d = period_act_q;
    for (int i = 0; i < NUM_CHANNELS; i++) duty_act_d[i] = duty_act_q[i];
`ifdef PWM_BANK_INVERT_EN
    invert_act_d = invert_act_q;
`endif
    cycles_d = cycles_q;
    // Uses the pre-write register values, so a write landing on the boundary
    // cycle waits for the following boundary.
    if (!en_q || boundary) begin
      center_act_d = center_q;
      period_act_d = period_q;
      for (int i = 0; i < NUM_CHANNELS; i++) duty_act_d[i] = duty_q[i];
`ifdef PWM_BANK_INVERT_EN
      invert_act_d = invert_q;
`endif
    end
    if (boundary) cycles_d = cycles_q + 32'd1;
    if (write && address == ADDR_CYCLES) cycles_d = '0;
  end

  // Comparators: the down phase compares inclusively so the high time is 2*duty ticks centred on cnt=0
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      pwm_d[i] = en_q & ((center_act_q & dir_q) ? (cnt_q <= duty_act_q[i])
                                                : (cnt_q <  duty_act_q[i]));
`ifdef PWM_BANK_INVERT_EN
      pwm_d[i] = pwm_d[i] ^ invert_act_q[i];
`endif
    end
  end

  // Read mux, registered for a fixed one-cycle latency; unmapped words read 0
  always_comb begin
    rdata = '0;
    if (address == ADDR_CTRL)   rdata[1:0]             = {center_q, en_q};
    if (address == ADDR_PERIOD) rdata[CNT_WIDTH-1:0]   = period_q;
    if (address == ADDR_PRESC)  rdata[PRESC_WIDTH-1:0] = presc_q;
    if (address == ADDR_CYCLES) rdata                  = cycles_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (address == ADDR_WIDTH'(4 + i)) rdata[CNT_WIDTH-1:0] = duty_q[i];
    end
`ifdef PWM_BANK_INVERT_EN
    if (address == ADDR_INVERT) begin
      rdata                    = '0;
      rdata[NUM_CHANNELS-1:0]  = invert_q;
    end
`endif
    readdata_d = read ? rdata : '0;
  end

  // State update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en_q         <= 1'b0;
      center_q     <= 1'b0;
      period_q     <= '0;
      presc_q      <= '0;
      cycles_q     <= '0;
      center_act_q <= 1'b0;
      period_act_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        duty_q[i]     <= '0;
        duty_act_q[i] <= '0;
      end
`ifdef PWM_BANK_INVERT_EN
      invert_q     <= '0;
      invert_act_q <= '0;
`endif
      presc_cnt_q  <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      pwm_q        <= '0;
      readdata_q   <= '0;
    end else begin
      en_q         <= en_d;
      center_q     <= center_d;
      period_q     <= period_d;
      presc_q      <= presc_d;
      cycles_q     <= cycles_d;
      center_act_q <= center_act_d;
      period_act_q <= period_act_d;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        duty_q[i]     <= duty_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
`ifdef PWM_BANK_INVERT_EN
      invert_q     <= invert_d;
      invert_act_q <= invert_act_d;
`endif
      presc_cnt_q  <= presc_cnt_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      pwm_q        <= pwm_d;
      readdata_q   <= readdata_d;
    end
  end

endmodule
